reg_file_param: RTL

//  Parametrised general-purpose register file for the model CPU datapath; successor to the fixed 3x8-bit file.
//  Two independent asynchronous read ports (source S, destination D) and one synchronous write port.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_wop_unit.sv | 34 +++
 rtl/reg_file_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and default constants for the parametrised register file
//   (reg_file_param) and its write-op unit (regfile_wop_unit).
//   Optional feature macro used by the top: REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_pkg;

   // Write-port operation codes. Encoding matches the 2-bit wop port.
   typedef enum logic [1:0] {
      WOP_LOAD = 2'b00,   // reg <= wd
      WOP_INC  = 2'b01,   // reg <= reg + 1 (modulo 2**DATA_W)
      WOP_DEC  = 2'b10,   // reg <= reg - 1 (modulo 2**DATA_W)
      WOP_CLR  = 2'b11    // reg <= 0
   } wop_e;

   // Default geometry: four 8-bit registers, register 2 acts as stack pointer.
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_REGS = 4;
   localparam int DEF_ADDR_W   = 2;
   localparam int DEF_SP_IDX   = 2;
   localparam int DEF_SP_INIT  = 'h80;

endpackage : regfile_pkg

// File: rtl/regfile_wop_unit.sv
// -----------------------------------------------------------------------------
// regfile_wop_unit
//   Combinational next-value computation for the register-file write port.
//   Used both to update the addressed register and, when REGFILE_BYPASS_EN is
//   defined in the top, to forward the value being written to the read ports.
//   INC/DEC wrap modulo 2**DATA_W; no carry or borrow is produced.
// -----------------------------------------------------------------------------
module regfile_wop_unit
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  wop_e              wop,
   input  logic [DATA_W-1:0] cur,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] nxt
);

   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   // Select the next register value for the requested write operation.
   always_comb begin
      // NOTE: assign a default before the case so every path drives nxt and no latch is inferred.
      nxt = cur;
      unique case (wop)
         WOP_LOAD: nxt = wd;
         WOP_INC:  nxt = cur + ONE;
         WOP_DEC:  nxt = cur - ONE;
         WOP_CLR:  nxt = '0;
         default:  nxt = cur;
      endcase
   end

endmodule : regfile_wop_unit

// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//   Parametrised general-purpose register file for the model CPU datapath.
//   - Two asynchronous read ports (S via ra, D via rb), zero latency.
//   - One synchronous write port with LOAD / INC / DEC / CLR operations, so a
//     register can serve as a stack pointer without going through the ALU.
//   - wr_mask[n] flags that register n has been written since the last reset.
//   - Synchronous active-high reset: all registers cleared except SP_IDX,
//     which loads SP_INIT; rst has priority over we.
//   - Out-of-range read addresses return reg[NUM_REGS-1]; out-of-range write
//     addresses are dropped (no register or wr_mask change).
//   Optional macro REGFILE_BYPASS_EN: when defined, a read port whose address
//   matches an in-range write address (we=1, rst=0) returns the value being
//   written this cycle. When undefined the written value appears a cycle later.
//   Constraints: 2 <= NUM_REGS <= 16, 2**ADDR_W >= NUM_REGS, SP_IDX < NUM_REGS.
// -----------------------------------------------------------------------------
module reg_file_param
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int SP_IDX   = DEF_SP_IDX,
   parameter int SP_INIT  = DEF_SP_INIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [1:0]          wop,
   input  logic [ADDR_W-1:0]   wa,
   input  logic [DATA_W-1:0]   wd,
   input  logic [ADDR_W-1:0]   ra,
   input  logic [ADDR_W-1:0]   rb,
   output logic [DATA_W-1:0]   s_out,
   output logic [DATA_W-1:0]   d_out,
   output logic [NUM_REGS-1:0] wr_mask
);

   // Reset value of the stack-pointer register, truncated/zero-extended.
   localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] wsel;      // one-hot decode of wa, all-zero when out of range
   logic                wa_ok;     // wa addresses an existing register
   logic [DATA_W-1:0]   cur_w;     // current contents of reg[wa]
   logic [DATA_W-1:0]   nxt_w;     // value reg[wa] takes on a write this cycle
   logic [DATA_W-1:0]   rd_s;      // stored value on the S port
   logic [DATA_W-1:0]   rd_d;      // stored value on the D port
   wop_e                wop_q;

   assign wop_q = wop_e'(wop);

   // Decode the write address and fetch the register it points at.
   always_comb begin
      wsel  = '0;
      cur_w = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wa == ADDR_W'(i)) begin
            wsel[i] = 1'b1;
            cur_w   = regs[i];
         end
      end
   end

   assign wa_ok = |wsel;

   regfile_wop_unit #(
      .DATA_W (DATA_W)
   ) u_wop (
      .wop (wop_q),
      .cur (cur_w),
      .wd  (wd),
      .nxt (nxt_w)
   );

   // Read muxes; any address past the last register falls back to it.
   always_comb begin
      rd_s = regs[NUM_REGS-1];
      rd_d = regs[NUM_REGS-1];
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ra == ADDR_W'(i)) rd_s = regs[i];
         if (rb == ADDR_W'(i)) rd_d = regs[i];
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic byp_s;
   logic byp_d;

   // Forward the in-flight write result to a port reading the same register.
   always_comb begin
      byp_s = we && !rst && wa_ok && (ra == wa);
      byp_d = we && !rst && wa_ok && (rb == wa);
      s_out = byp_s ? nxt_w : rd_s;
      d_out = byp_d ? nxt_w : rd_d;
   end
`else
   // Read ports always show stored contents; writes become visible next cycle.
   always_comb begin
      s_out = rd_s;
      d_out = rd_d;
   end
`endif

   // Register array: synchronous reset to known values, then one write per cycle.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         // NOTE: each array element is reset explicitly; this is a flop array, not a RAM macro, and SP needs a non-zero start.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == SP_IDX) ? SP_RST : '0;
         end
      end else if (we) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wsel[i]) regs[i] <= nxt_w;
         end
      end
   end

   // Written-since-reset flags; out-of-range writes leave wsel empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_mask <= '0;
      end else if (we) begin
         wr_mask <= wr_mask | wsel;
      end
   end

endmodule : reg_file_param
